// File: rtl/data_cache_pkg.sv
// Shared widths, FSM state encoding and a word-select helper for the data cache.
package data_cache_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int MEM_DATA_WIDTH = 128;
  localparam int CACHE_LINES    = 4;
  localparam int WORDS_PER_LINE = MEM_DATA_WIDTH / WORD_WIDTH;

  typedef enum logic [1:0] {
    CACHE_IDLE = 2'd0,
    CACHE_WB   = 2'd1,
    CACHE_FILL = 2'd2
  } cache_state_e;

  // Word w of a line lives at [127-32w -: 32]: lowest address in the MSBs.
  function automatic logic [WORD_WIDTH-1:0] get_word(input logic [MEM_DATA_WIDTH-1:0] line,
                                                     input logic [1:0] off);
    logic [WORD_WIDTH-1:0] w;
    case (off)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache.
// Handshake: the CPU presents cpu_req with a stable address/data; the access
// completes on the first rising edge where cpu_stall is low. Memory requests
// (mem_req) are held stable for a fixed number of cycles and need no ready.
interface data_cache_if;
  import data_cache_pkg::*;

  logic                      cpu_req;
  logic                      cpu_we;
  logic [31:0]               cpu_addr;
  logic [WORD_WIDTH-1:0]     cpu_wdata;
  logic [WORD_WIDTH-1:0]     cpu_rdata;
  logic                      cpu_stall;
  logic                      mem_req;
  logic                      mem_we;
  logic [31:0]               mem_addr;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata;
  logic [MEM_DATA_WIDTH-1:0] mem_rdata;

  // Environment side: CPU driver plus main memory.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Cache side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_cache_storage.sv
// Valid/dirty/tag/data arrays with a combinational read port, a word write
// port (marks the line dirty), a line write port (installs a clean line)
// and a synchronous clear of all valid and dirty bits.
module data_cache_storage
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = 2,
  parameter int TAG_W     = 26
) (
  input  logic                      clk_i,
  input  logic                      clear_i,
  input  logic [IDX_W-1:0]          rd_idx_i,
  output logic                      rd_valid_o,
  output logic                      rd_dirty_o,
  output logic [TAG_W-1:0]          rd_tag_o,
  output logic [MEM_DATA_WIDTH-1:0] rd_line_o,
  input  logic                      ww_en_i,
  input  logic [IDX_W-1:0]          ww_idx_i,
  input  logic [1:0]                ww_off_i,
  input  logic [WORD_WIDTH-1:0]     ww_data_i,
  input  logic                      lw_en_i,
  input  logic [IDX_W-1:0]          lw_idx_i,
  input  logic [TAG_W-1:0]          lw_tag_i,
  input  logic [MEM_DATA_WIDTH-1:0] lw_line_i
);

  logic [NUM_LINES-1:0]      valid_q;
  logic [NUM_LINES-1:0]      dirty_q;
  logic [TAG_W-1:0]          tag_q  [NUM_LINES];
  logic [MEM_DATA_WIDTH-1:0] data_q [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // Status bits: cleared on reset, set by line install / word store.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (lw_en_i) begin
        valid_q[lw_idx_i] <= 1'b1;
        dirty_q[lw_idx_i] <= 1'b0;
      end
      if (ww_en_i) begin
        dirty_q[ww_idx_i] <= 1'b1;
      end
    end
  end

  // Tag and data payload: not reset, only meaningful under a valid bit.
  always_ff @(posedge clk_i) begin
    if (lw_en_i) begin
      tag_q[lw_idx_i]  <= lw_tag_i;
      data_q[lw_idx_i] <= lw_line_i;
    end
    if (ww_en_i) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        if (ww_off_i == 2'(w)) begin
          data_q[ww_idx_i][MEM_DATA_WIDTH-1-WORD_WIDTH*w -: WORD_WIDTH] <= ww_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache. Hits complete in the
// access cycle; misses run a timed write-back and/or fill with main memory.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_LINES   = CACHE_LINES,
  parameter int MEM_LATENCY = 5
) (
  input  logic         clk,
  input  logic         reset,
  data_cache_if.slave  bus,
  output cache_state_e state_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - 4 - IDX_W;
  localparam int CW    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  cache_state_e              state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [TAG_W-1:0]          lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0]          lat_idx_q, lat_idx_d;
  logic                      mem_req_q, mem_req_d;
  logic                      mem_we_q, mem_we_d;
  logic [31:0]               mem_addr_q, mem_addr_d;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]          addr_tag;
  logic [IDX_W-1:0]          addr_idx;
  logic [1:0]                addr_off;
  logic                      rd_valid, rd_dirty;
  logic [TAG_W-1:0]          rd_tag;
  logic [MEM_DATA_WIDTH-1:0] rd_line;
  logic                      hit, miss;
  logic                      ww_en, lw_en;
  logic                      unused_addr_bits;

  assign addr_off         = bus.cpu_addr[3:2];
  assign addr_idx         = bus.cpu_addr[4 +: IDX_W];
  assign addr_tag         = bus.cpu_addr[31 -: TAG_W];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  data_cache_storage #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_storage (
    .clk_i      (clk),
    .clear_i    (reset),
    .rd_idx_i   (addr_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .ww_en_i    (ww_en),
    .ww_idx_i   (addr_idx),
    .ww_off_i   (addr_off),
    .ww_data_i  (bus.cpu_wdata),
    .lw_en_i    (lw_en),
    .lw_idx_i   (lat_idx_q),
    .lw_tag_i   (lat_tag_q),
    .lw_line_i  (bus.mem_rdata)
  );

  // Hit/miss only resolve in IDLE; reset masks them so outputs read as idle.
  assign hit  = !reset && bus.cpu_req && (state_q == CACHE_IDLE) && rd_valid && (rd_tag == addr_tag);
  assign miss = !reset && bus.cpu_req && (state_q == CACHE_IDLE) && !hit;

  assign bus.cpu_stall = !reset && ((state_q != CACHE_IDLE) || miss);
  assign bus.cpu_rdata = (hit && !bus.cpu_we) ? get_word(rd_line, addr_off) : '0;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign state_o       = state_q;

  // State, latency counter, latched miss address and registered memory request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CACHE_IDLE;
      cnt_q       <= '0;
      lat_tag_q   <= '0;
      lat_idx_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_tag_q   <= lat_tag_d;
      lat_idx_q   <= lat_idx_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic: miss detection, timed write-back, timed fill.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_tag_d   = lat_tag_q;
    lat_idx_d   = lat_idx_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ww_en       = 1'b0;
    lw_en       = 1'b0;
    case (state_q)
      CACHE_IDLE: begin
        if (hit && bus.cpu_we) begin
          ww_en = 1'b1;
        end
        if (miss) begin
          lat_tag_d = addr_tag;
          lat_idx_d = addr_idx;
          cnt_d     = CW'(MEM_LATENCY - 1);
          mem_req_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d     = CACHE_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {rd_tag, addr_idx, 4'b0};
            mem_wdata_d = rd_line;
          end else begin
            state_d     = CACHE_FILL;
            mem_we_d    = 1'b0;
            mem_addr_d  = {addr_tag, addr_idx, 4'b0};
            mem_wdata_d = '0;
          end
        end
      end
      CACHE_WB: begin
        if (cnt_q == '0) begin
          state_d     = CACHE_FILL;
          cnt_d       = CW'(MEM_LATENCY - 1);
          mem_we_d    = 1'b0;
          mem_addr_d  = {lat_tag_q, lat_idx_q, 4'b0};
          mem_wdata_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CACHE_FILL: begin
        if (cnt_q == '0) begin
          lw_en      = !reset;
          state_d    = CACHE_IDLE;
          mem_req_d  = 1'b0;
          mem_addr_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = CACHE_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: reset values, hits, clean/dirty misses,
// write-allocate, word select and reset in the middle of a fill.
module tb_data_cache;
  import data_cache_pkg::*;

  logic         clk;
  logic         reset;
  cache_state_e state_dbg;
  int           n_run;
  int           n_fail;

  data_cache_if bus();

  data_cache #(
    .NUM_LINES   (4),
    .MEM_LATENCY (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main-memory model: fixed line contents per line address.
  function automatic logic [127:0] mem_line(input logic [31:0] a);
    case (a)
      32'h40:  return 128'h11111111_22222222_33333333_44444444;
      32'h50:  return 128'h50505050_51515151_52525252_53535353;
      32'h80:  return 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
      32'h90:  return 128'h90909090_91919191_92929292_93939393;
      32'hC0:  return 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
      32'h100: return 128'h01000100_01010101_01020102_01030103;
      default: return '0;
    endcase
  endfunction

  assign bus.mem_rdata = mem_line(bus.mem_addr);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observations of one CPU access.
  int          stall_n, wb_n, fill_n;
  logic [31:0] rdata, wb_addr, fill_addr;
  logic [127:0] wb_data;
  logic        unstable;

  // Called just after a rising edge; returns just after the completing edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    stall_n = 0; wb_n = 0; fill_n = 0; unstable = 1'b0;
    wb_addr = '0; fill_addr = '0; wb_data = '0; rdata = '0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    forever begin
      @(negedge clk);
      if (!bus.cpu_stall) begin
        rdata = bus.cpu_rdata;
        break;
      end
      stall_n++;
      if (bus.mem_req && bus.mem_we) begin
        wb_n++;
        if (wb_n == 1) begin
          wb_addr = bus.mem_addr;
          wb_data = bus.mem_wdata;
        end else if (bus.mem_addr !== wb_addr || bus.mem_wdata !== wb_data) begin
          unstable = 1'b1;
        end
      end else if (bus.mem_req) begin
        fill_n++;
        if (fill_n == 1) fill_addr = bus.mem_addr;
        else if (bus.mem_addr !== fill_addr) unstable = 1'b1;
      end
      if (stall_n > 100) begin
        check("stall_timeout", 1, 0);
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, bus.cpu_stall, 0);
    check({tag, "_rdata"}, bus.cpu_rdata, 0);
    check({tag, "_mem_req"}, bus.mem_req, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst_high");
    check("rst_state", state_dbg, CACHE_IDLE);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_after");
    @(posedge clk); #1;

    // Cold load miss.
    access(1'b0, 32'h40, '0);
    check("cold_stall", stall_n, 6);
    check("cold_fill_n", fill_n, 5);
    check("cold_wb_n", wb_n, 0);
    check("cold_fill_addr", fill_addr, 32'h40);
    check("cold_rdata", rdata, 32'h11111111);
    check("cold_stable", unstable, 0);

    // Word select on a hit.
    access(1'b0, 32'h4C, '0);
    check("wsel_stall", stall_n, 0);
    check("wsel_rdata", rdata, 32'h44444444);
    check("wsel_mem_req", bus.mem_req, 0);

    // Store hit then reload.
    access(1'b1, 32'h44, 32'hDEADBEEF);
    check("st_hit_stall", stall_n, 0);
    check("st_hit_rdata", rdata, 0);
    access(1'b0, 32'h44, '0);
    check("st_reload", rdata, 32'hDEADBEEF);
    check("st_reload_stall", stall_n, 0);

    // Dirty eviction of index 0.
    access(1'b0, 32'h80, '0);
    check("dirty_stall", stall_n, 11);
    check("dirty_wb_n", wb_n, 5);
    check("dirty_wb_addr", wb_addr, 32'h40);
    check("dirty_wb_data", wb_data, 128'h11111111_DEADBEEF_33333333_44444444);
    check("dirty_fill_n", fill_n, 5);
    check("dirty_fill_addr", fill_addr, 32'h80);
    check("dirty_rdata", rdata, 32'hA0A0A0A0);
    check("dirty_stable", unstable, 0);

    // Clean eviction: valid clean victim, no write-back.
    access(1'b0, 32'hC0, '0);
    check("clean_stall", stall_n, 6);
    check("clean_wb_n", wb_n, 0);
    check("clean_fill_addr", fill_addr, 32'hC0);
    check("clean_rdata", rdata, 32'hC0C0C0C0);

    // Store miss allocates the line, then the word is merged.
    access(1'b1, 32'h54, 32'hCAFEF00D);
    check("stmiss_stall", stall_n, 6);
    check("stmiss_fill_addr", fill_addr, 32'h50);
    access(1'b0, 32'h54, '0);
    check("stmiss_reload", rdata, 32'hCAFEF00D);
    access(1'b0, 32'h58, '0);
    check("stmiss_neighbour", rdata, 32'h52525252);

    // Dirty eviction of index 1 carries the merged word out.
    access(1'b0, 32'h94, '0);
    check("dirty1_stall", stall_n, 11);
    check("dirty1_wb_addr", wb_addr, 32'h50);
    check("dirty1_wb_data", wb_data, 128'h50505050_CAFEF00D_52525252_53535353);
    check("dirty1_rdata", rdata, 32'h91919191);
    access(1'b1, 32'h98, 32'h12345678);
    check("dirty1_st_stall", stall_n, 0);

    // Reset in the 3rd FILL cycle.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
    @(negedge clk);
    check("rmf_miss_stall", bus.cpu_stall, 1);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    check("rmf_in_fill", state_dbg, CACHE_FILL);
    reset = 1'b1; bus.cpu_req = 1'b0;
    @(negedge clk);
    check("rmf_rst_stall", bus.cpu_stall, 0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("rmf_mem_req", bus.mem_req, 0);
    check("rmf_stall", bus.cpu_stall, 0);
    check("rmf_state", state_dbg, CACHE_IDLE);
    @(posedge clk); #1;
    access(1'b0, 32'h100, '0);
    check("rmf_reload_stall", stall_n, 6);
    check("rmf_reload_wb_n", wb_n, 0);
    check("rmf_reload_rdata", rdata, 32'h01000100);
    // Dirty line at index 1 was discarded by reset: clean miss, no write-back.
    access(1'b0, 32'h94, '0);
    check("rmf_discard_stall", stall_n, 6);
    check("rmf_discard_wb_n", wb_n, 0);
    check("rmf_discard_rdata", rdata, 32'h91919191);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
